// File: rtl/v_quad_decoder.sv
// Quadrature decoder: synchronises encoder phases A/B, decodes x4 steps into a
// one-cycle count strobe with direction, keeps a wrapping position count and a sticky error flag.
module v_quad_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             A,
    input  logic             B,
    output logic             CE,
    output logic             UP_DOWN,
    output logic [WIDTH-1:0] Q,
    output logic             ERR
);

    localparam logic signed [1:0] STEP_UP = 2'sd1;
    localparam logic signed [1:0] STEP_DN = -2'sd1;

    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       prev_q;
    logic [1:0]       diff;
    logic             ce_q, ce_d;
    logic             up_q, up_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_q, q_d;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] v,
                                                  input logic signed [1:0] delta);
        logic signed [WIDTH-1:0] delta_ext;
        delta_ext = WIDTH'(delta);
        return v + delta_ext;
    endfunction

    // Synchroniser and previous-pair flops run freely, CLR never touches them
    always_ff @(posedge C) begin
        s1_q   <= {A, B};
        s2_q   <= s1_q;
        prev_q <= s2_q;
    end

    assign diff = s2_q ^ prev_q;

    always_comb begin
        ce_d  = 1'b0;
        up_d  = up_q;
        err_d = err_q;
        q_d   = q_q;
        if (diff == 2'b11) begin
            err_d = 1'b1;
        end else if (diff != 2'b00) begin
            // Up when the new B equals the old A (A leads B)
            ce_d = 1'b1;
            up_d = ~(prev_q[1] ^ s2_q[0]);
            q_d  = wrap_add(q_q, up_d ? STEP_UP : STEP_DN);
        end
    end

    always_ff @(posedge C) begin
        if (CLR) begin
            ce_q  <= 1'b0;
            up_q  <= 1'b1;
            err_q <= 1'b0;
            q_q   <= '0;
        end else begin
            ce_q  <= ce_d;
            up_q  <= up_d;
            err_q <= err_d;
            q_q   <= q_d;
        end
    end

    assign CE      = ce_q;
    assign UP_DOWN = up_q;
    assign ERR     = err_q;
    assign Q       = q_q;

endmodule

// File: tb/tb_v_quad_decoder.sv
// Bench for v_quad_decoder: vector table, directed corner sequences and random
// phase motion, all compared against a phase-position reference model.
module tb_v_quad_decoder;

    logic       C;
    logic       CLR;
    logic       A;
    logic       B;
    logic       CE;
    logic       UP_DOWN;
    logic [3:0] Q;
    logic       ERR;

    v_quad_decoder #(.WIDTH(4)) dut (
        .C(C), .CLR(CLR), .A(A), .B(B),
        .CE(CE), .UP_DOWN(UP_DOWN), .Q(Q), .ERR(ERR)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    typedef struct {
        logic [1:0] ab;
        logic       clr;
        logic       ce;
        logic       ud;
        logic [3:0] q;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [1:0] hist[$];
    int         m_q;
    bit         m_ce, m_ud, m_err;
    int         cur_pos = 0;

    function automatic logic [1:0] pos_to_ab(input int p);
        case (p)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int ab_to_pos(input logic [1:0] ab);
        for (int i = 0; i < 4; i++)
            if (pos_to_ab(i) == ab) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output after edge k reflects the pair sampled at edge k-2 against edge k-3
    task automatic model_edge(input logic [1:0] ab, input logic clr);
        int d;
        hist.push_back(ab);
        if (hist.size() > 4) void'(hist.pop_front());
        m_ce = 1'b0;
        if (clr) begin
            m_q = 0; m_ud = 1'b1; m_err = 1'b0;
        end else if (hist.size() == 4) begin
            d = (ab_to_pos(hist[1]) - ab_to_pos(hist[0]) + 4) % 4;
            if (d == 1) begin
                m_ce = 1'b1; m_ud = 1'b1; m_q = (m_q + 1) % 16;
            end else if (d == 3) begin
                m_ce = 1'b1; m_ud = 1'b0; m_q = (m_q + 15) % 16;
            end else if (d == 2) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [1:0] ab, input logic clr);
        A = ab[1]; B = ab[0]; CLR = clr;
        @(posedge C);
        model_edge(ab, clr);
        #1;
        chk("model", {28'd0, CE, UP_DOWN, Q[1:0]} ^ {24'd0, 4'd0, 2'd0, Q[3:2], 2'd0} ,
            {28'd0, m_ce, m_ud, 2'(m_q)} ^ {24'd0, 4'd0, 2'd0, 2'(m_q >> 2), 2'd0});
        chk("model_err", {31'd0, ERR}, {31'd0, m_err});
    endtask

    task automatic move(input int d, input logic clr, input int hold);
        cur_pos = (cur_pos + d + 4) % 4;
        for (int i = 0; i < hold; i++) step(pos_to_ab(cur_pos), clr);
    endtask

    task automatic add(input logic [1:0] ab, input logic clr, input logic ce,
                       input logic ud, input int q, input logic err);
        vec_t v;
        v.ab = ab; v.clr = clr; v.ce = ce; v.ud = ud; v.q = 4'(q); v.err = err;
        tbl.push_back(v);
    endtask

    task automatic settle_at_zero();
        cur_pos = 0;
        move(0, 1'b1, 4);
        move(0, 1'b0, 2);
    endtask

    initial begin
        int strobes, run, best, ud_at[$], ce_seen;
        A = 1'b1; B = 1'b1; CLR = 1'b1;

        // Vector table: static 11 through reset, then up sequence from 00
        for (int i = 0; i < 5; i++)  add(2'b11, 1'b1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(2'b11, 1'b0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++)  add(2'b00, 1'b1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++)  add(2'b00, 1'b0, 0, 1, 0, 0);
        for (int s = 0; s < 4; s++)
            for (int h = 0; h < 4; h++)
                add(pos_to_ab((s + 1) % 4), 1'b0, (h == 2), 1, (h >= 2) ? s + 1 : s, 0);
        for (int i = 0; i < 2; i++)  add(2'b00, 1'b0, 0, 1, 4, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ab, tbl[i].clr);
            chk($sformatf("tbl[%0d]", i), {24'd0, CE, UP_DOWN, ERR, 1'b0, Q},
                {24'd0, tbl[i].ce, tbl[i].ud, tbl[i].err, 1'b0, tbl[i].q});
        end

        // Down through zero with wrap
        settle_at_zero();
        move(1, 1'b0, 4);
        chk("wrap_q1", {28'd0, Q}, 32'd1);
        move(-1, 1'b0, 4);
        chk("wrap_q0", {28'd0, Q}, 32'd0);
        chk("wrap_ud0", {31'd0, UP_DOWN}, 32'd0);
        move(-1, 1'b0, 4);
        chk("wrap_q15", {28'd0, Q}, 32'd15);
        move(-1, 1'b0, 4);
        chk("wrap_q14", {28'd0, Q}, 32'd14);
        chk("wrap_ud", {31'd0, UP_DOWN}, 32'd0);

        // Back-to-back: 8 up then 3 down, one change per cycle
        settle_at_zero();
        strobes = 0; run = 0; best = 0;
        for (int i = 0; i < 15; i++) begin
            if (i < 8)       move(1, 1'b0, 1);
            else if (i < 11) move(-1, 1'b0, 1);
            else             move(0, 1'b0, 1);
            if (CE) begin
                strobes++; run++; ud_at.push_back(int'(UP_DOWN));
                if (run > best) best = run;
            end else run = 0;
        end
        chk("b2b_strobes", strobes, 32'd11);
        chk("b2b_run", best, 32'd11);
        chk("b2b_q", {28'd0, Q}, 32'd5);
        if (ud_at.size() == 11) begin
            chk("b2b_ud8", ud_at[7], 32'd1);
            chk("b2b_ud9", ud_at[8], 32'd0);
        end else chk("b2b_udlen", ud_at.size(), 32'd11);

        // Illegal double-phase jump, then a legal step
        settle_at_zero();
        ce_seen = 0;
        for (int i = 0; i < 4; i++) begin
            move((i == 0) ? 2 : 0, 1'b0, 1);
            ce_seen += int'(CE);
        end
        chk("ill_ce", ce_seen, 32'd0);
        chk("ill_q", {28'd0, Q}, 32'd0);
        chk("ill_err", {31'd0, ERR}, 32'd1);
        move(1, 1'b0, 4);
        chk("ill_next_q", {28'd0, Q}, 32'd1);
        chk("ill_next_err", {31'd0, ERR}, 32'd1);
        chk("ill_next_ud", {31'd0, UP_DOWN}, 32'd1);

        // One-cycle CLR while streaming, with ERR set beforehand
        settle_at_zero();
        move(2, 1'b0, 3);
        for (int i = 0; i < 6; i++) move(1, 1'b0, 1);
        move(1, 1'b1, 1);
        chk("clr_q", {28'd0, Q}, 32'd0);
        chk("clr_ce", {31'd0, CE}, 32'd0);
        chk("clr_err", {31'd0, ERR}, 32'd0);
        chk("clr_ud", {31'd0, UP_DOWN}, 32'd1);
        move(1, 1'b0, 1);
        chk("clr_resume_ce", {31'd0, CE}, 32'd1);
        chk("clr_resume_q", {28'd0, Q}, 32'd1);

        // Random motion: idle, up, down, illegal jumps and occasional CLR
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 35)      move(0, 1'b0, 1);
            else if (r < 65) move(1, 1'b0, 1);
            else if (r < 93) move(-1, 1'b0, 1);
            else if (r < 97) move(2, 1'b0, 1);
            else             move(int'($urandom_range(0, 1)), 1'b1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
